// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-master arbiter for data-memory port B (optional m1 write protection: MEM_ARB_PROTECT_EN)
module mem_port_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int RD_LATENCY   = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
`ifdef MEM_ARB_PROTECT_EN
    output logic              m1_err,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int WW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [WW-1:0] WAIT_INIT  = WW'(RD_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SW-1:0]     r_starve_cnt;
    logic [WW-1:0]     r_wait_cnt;
    logic              r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_m0_rdata;
    logic [DATA_W-1:0] r_m1_rdata;

    logic w_any_req;
    logic w_grant_m1;
    logic w_block;
    logic w_mem_we;
    logic w_m0_ack;
    logic w_m1_ack;
    logic w_m1_err;

    assign w_any_req  = m0_req | m1_req;
    // Starvation override only applies while m1 is actually asking.
    assign w_grant_m1 = m1_req & ((r_starve_cnt == STARVE_MAX) | ~m0_req);

`ifdef MEM_ARB_PROTECT_EN
    // Loader writes into the MMIO or exception-vector windows are suppressed but still acked.
    assign w_block = r_owner & r_we &
                     ((r_addr[31:16] == 16'hffff) | (r_addr[31:16] == 16'h1c09));
`else
    assign w_block = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mem_we    = 1'b0;
        w_m0_ack    = 1'b0;
        w_m1_ack    = 1'b0;
        w_m1_err    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_mem_we    = r_we & ~w_block;
                w_state_nxt = r_we ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_m0_ack    = ~r_owner;
                w_m1_ack    = r_owner;
                w_m1_err    = r_owner & w_block;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starve_cnt <= '0;
            r_wait_cnt   <= '0;
            r_owner      <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
        end else begin
            if (r_state == S_IDLE) begin
                if (w_any_req) begin
                    r_owner <= w_grant_m1;
                    r_we    <= w_grant_m1 ? m1_we    : m0_we;
                    r_addr  <= w_grant_m1 ? m1_addr  : m0_addr;
                    r_wdata <= w_grant_m1 ? m1_wdata : m0_wdata;
                end
                if (!m1_req || w_grant_m1) begin
                    r_starve_cnt <= '0;
                end else if (r_starve_cnt != STARVE_MAX) begin
                    r_starve_cnt <= r_starve_cnt + SW'(1);
                end
            end

            if (r_state == S_ISSUE) begin
                r_wait_cnt <= WAIT_INIT;
            end else if ((r_state == S_WAIT) && (r_wait_cnt != '0)) begin
                r_wait_cnt <= r_wait_cnt - WW'(1);
            end

            // Each master's read data only moves on its own read, so an unacked value survives the other side.
            if ((r_state == S_WAIT) && (r_wait_cnt == '0)) begin
                if (r_owner) begin
                    r_m1_rdata <= mem_rdata;
                end else begin
                    r_m0_rdata <= mem_rdata;
                end
            end
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_we    = w_mem_we;
    assign owner     = r_owner;
    assign m0_ack    = w_m0_ack;
    assign m1_ack    = w_m1_ack;
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;

`ifdef MEM_ARB_PROTECT_EN
    assign m1_err = w_m1_err;
`else
    logic w_unused;
    assign w_unused = w_m1_err;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter (MEM_ARB_PROTECT_EN aware)
module tb_mem_port_arbiter;

`ifdef MEM_ARB_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic        owner;
`ifdef MEM_ARB_PROTECT_EN
    logic        m1_err;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .m0_req   (m0_req),
        .m0_we    (m0_we),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_ack   (m0_ack),
        .m0_rdata (m0_rdata),
        .m1_req   (m1_req),
        .m1_we    (m1_we),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_ack   (m1_ack),
        .m1_rdata (m1_rdata),
`ifdef MEM_ARB_PROTECT_EN
        .m1_err   (m1_err),
`endif
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .mem_rdata(mem_rdata),
        .owner    (owner)
    );

    // Port-B memory with one cycle of read latency.
    logic [31:0] mem [0:63];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[7:2]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          cyc;
        bit          rd;
        logic [31:0] rdata;
        bit          err;
    } ack_t;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    ack_t q0[$];
    ack_t q1[$];
    wr_t  qw[$];
    ack_t e0, e1;
    wr_t  ew;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ack(input int m, input int c, input bit rd, input logic [31:0] rdata, input bit err);
        ack_t a;
        a.cyc = c; a.rd = rd; a.rdata = rdata; a.err = err;
        if (m == 0) q0.push_back(a); else q1.push_back(a);
    endtask

    task automatic push_wr(input int c, input logic [31:0] addr, input logic [31:0] data);
        wr_t w;
        w.cyc = c; w.addr = addr; w.data = data;
        qw.push_back(w);
    endtask

    // Monitor: every ack and every port-B write strobe consumes one scoreboard entry.
    always @(negedge clk) begin
        if (m0_ack) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL m0_ack_unexpected: got ack at cyc %0d expected none", cyc);
            end else begin
                e0 = q0.pop_front();
                check("m0_ack_cyc", cyc, e0.cyc);
                check("m0_owner", 32'(owner), 32'd0);
                if (e0.rd) check("m0_rdata", m0_rdata, e0.rdata);
            end
        end
        if (m1_ack) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL m1_ack_unexpected: got ack at cyc %0d expected none", cyc);
            end else begin
                e1 = q1.pop_front();
                check("m1_ack_cyc", cyc, e1.cyc);
                check("m1_owner", 32'(owner), 32'd1);
                if (e1.rd) check("m1_rdata", m1_rdata, e1.rdata);
`ifdef MEM_ARB_PROTECT_EN
                check("m1_err", 32'(m1_err), 32'(e1.err));
`endif
            end
        end
        if (mem_we) begin
            if (qw.size() == 0) begin
                checks++; errors++;
                $display("FAIL mem_we_unexpected: got write addr %0h at cyc %0d expected none", mem_addr, cyc);
            end else begin
                ew = qw.pop_front();
                check("wr_cyc", cyc, ew.cyc);
                check("wr_addr", mem_addr, ew.addr);
                check("wr_data", mem_wdata, ew.data);
            end
        end
    end

    task automatic tick_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int m, input bit req, input bit we, input logic [31:0] addr, input logic [31:0] data);
        if (m == 0) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = data;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = data;
        end
    endtask

    task automatic drop(input int m);
        if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
    endtask

    // Lone transaction issued in an IDLE cycle; for reads, data is the expected read value.
    task automatic txn(input int m, input bit we, input logic [31:0] addr, input logic [31:0] data,
                       input bit filt, input bit err);
        int k;
        k = cyc;
        drive(m, 1'b1, we, addr, data);
        if (we) begin
            push_ack(m, k + 2, 1'b0, 32'h0, err);
            if (!filt) push_wr(k + 1, addr, data);
            tick_to(k + 3);
        end else begin
            push_ack(m, k + 3, 1'b1, data, 1'b0);
            tick_to(k + 4);
        end
        drop(m);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m0_ack"},    32'(m0_ack),    32'd0);
        check({tag, "_m1_ack"},    32'(m1_ack),    32'd0);
        check({tag, "_m0_rdata"},  m0_rdata,       32'd0);
        check({tag, "_m1_rdata"},  m1_rdata,       32'd0);
        check({tag, "_mem_addr"},  mem_addr,       32'd0);
        check({tag, "_mem_wdata"}, mem_wdata,      32'd0);
        check({tag, "_mem_we"},    32'(mem_we),    32'd0);
        check({tag, "_owner"},     32'(owner),     32'd0);
    endtask

    initial begin
        int k;
        reset = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("por");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        txn(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0);
        txn(0, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0);
        tick_to(cyc + 2);
        check("m0_rdata_held", m0_rdata, 32'hDEAD_BEEF);

        txn(1, 1'b1, 32'h0000_0020, 32'h1234_5678, 1'b0, 1'b0);
        txn(1, 1'b0, 32'h0000_0020, 32'h1234_5678, 1'b0, 1'b0);
        check("m0_rdata_kept_over_m1", m0_rdata, 32'hDEAD_BEEF);
        txn(0, 1'b1, 32'h0000_0030, 32'hCAFE_F00D, 1'b0, 1'b0);
        txn(0, 1'b0, 32'h0000_0030, 32'hCAFE_F00D, 1'b0, 1'b0);
        check("m1_rdata_kept_over_m0", m1_rdata, 32'h1234_5678);

        // Simultaneous requests: m0 first, m1 on the following slot.
        k = cyc;
        drive(0, 1'b1, 1'b1, 32'h0000_0040, 32'h1111_1111);
        drive(1, 1'b1, 1'b1, 32'h0000_0044, 32'h2222_2222);
        push_ack(0, k + 2, 1'b0, 32'h0, 1'b0);
        push_wr(k + 1, 32'h0000_0040, 32'h1111_1111);
        push_ack(1, k + 5, 1'b0, 32'h0, 1'b0);
        push_wr(k + 4, 32'h0000_0044, 32'h2222_2222);
        tick_to(k + 3);
        drop(0);
        tick_to(k + 6);
        drop(1);

        // Both held: eight m0 grants, then m1 forced in, then m0 again.
        k = cyc;
        drive(0, 1'b1, 1'b1, 32'h0000_0050, 32'hA5A5_A5A5);
        drive(1, 1'b1, 1'b1, 32'h0000_0054, 32'h5A5A_5A5A);
        for (int i = 0; i < 8; i++) begin
            push_ack(0, k + 2 + 3 * i, 1'b0, 32'h0, 1'b0);
            push_wr(k + 1 + 3 * i, 32'h0000_0050, 32'hA5A5_A5A5);
        end
        push_ack(1, k + 26, 1'b0, 32'h0, 1'b0);
        push_wr(k + 25, 32'h0000_0054, 32'h5A5A_5A5A);
        push_ack(0, k + 29, 1'b0, 32'h0, 1'b0);
        push_wr(k + 28, 32'h0000_0050, 32'hA5A5_A5A5);
        tick_to(k + 27);
        drop(1);
        tick_to(k + 30);
        drop(0);
        tick_to(cyc + 1);

        // Reset in the middle of a read's WAIT cycle: no ack, outputs clear at once.
        k = cyc;
        drive(0, 1'b1, 1'b0, 32'h0000_0030, 32'h0);
        tick_to(k + 2);
        #1;
        reset = 1'b0;
        #1;
        check_reset_outputs("mid");
        drop(0);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        txn(0, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0);

        txn(1, 1'b1, 32'hFFFF_0000, 32'hBAD0_BAD0, PROT, PROT);
        txn(1, 1'b1, 32'h1C09_0004, 32'hBAD1_BAD1, PROT, PROT);
        txn(1, 1'b1, 32'h0000_0020, 32'h0BAD_F00D, 1'b0, 1'b0);
        txn(0, 1'b1, 32'hFFFF_0008, 32'h7777_7777, 1'b0, 1'b0);
        txn(1, 1'b0, 32'h0000_0020, 32'h0BAD_F00D, 1'b0, 1'b0);
        txn(0, 1'b0, 32'hFFFF_0008, 32'h7777_7777, 1'b0, 1'b0);

        tick_to(cyc + 6);
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        check("qw_drained", 32'(qw.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares data-memory port B between two requesters: the CPU load/store unit (m0) and the UART program/data loader (m1).
- Runs one transaction at a time through a small FSM and drives the memory's port-B address, write-data and write-enable pins.
- Returns read data and a one-cycle ack to the winning master.
- CPU has fixed priority; an aging counter keeps the loader from starving.

Parameters:
- DATA_W, 32, data bus width.
- ADDR_W, 32, address bus width.
- RD_LATENCY, 1, cycles from address issue to valid mem_rdata (>=1).
- STARVE_LIMIT, 8, consecutive lost arbitrations after which m1 is forced to win (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- m0_req  in  1  CPU request; held with m0_we/m0_addr/m0_wdata stable until m0_ack
- m0_we  in  1  1 = write, 0 = read
- m0_addr  in  ADDR_W  byte address
- m0_wdata  in  DATA_W  write data
- m0_ack  out  1  one-cycle completion pulse
- m0_rdata  out  DATA_W  read data, valid with m0_ack, held until the next m0 read ack
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata  same as m0_*, loader side
- mem_addr  out  ADDR_W  to port-B address
- mem_wdata  out  DATA_W  to port-B write data
- mem_we  out  1  to port-B write enable
- mem_rdata  in  DATA_W  from port-B read data
- owner  out  1  0 = m0 owns the port, 1 = m1 owns it; valid outside IDLE

Behaviour:
- Reset (async, reset=0):
  - state=IDLE, starve_cnt=0.
  - All outputs 0, including rdata registers, owner and mem_we.
  - Any in-flight transaction is dropped with no ack; mem_we falls immediately.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high, pick the winner and latch its we/addr/wdata and owner; go to ISSUE.
  - Otherwise stay in IDLE.
- Winner selection:
  - m1 wins if starve_cnt==STARVE_LIMIT, or if m1_req is high and m0_req is low.
  - Otherwise m0 wins.
- Starve counter:
  - starve_cnt increments (saturating) when m1_req=1 and m0 wins.
  - It clears when m1 is granted or when m1_req=0 in IDLE.
- ISSUE (1 cycle):
  - mem_addr/mem_wdata are driven from the latched values.
  - mem_we = latched we, for exactly this one cycle.
  - Write: next state RESP. Read: next state WAIT with wait_cnt=RD_LATENCY-1.
- WAIT:
  - If wait_cnt==0, capture mem_rdata into the owner's rdata register and go to RESP.
  - Otherwise decrement wait_cnt.
- RESP:
  - Pulse the owner's ack for 1 cycle; go to IDLE.
- Latency from the IDLE cycle that samples req:
  - Write: ack 2 cycles later.
  - Read: ack RD_LATENCY+2 cycles later (3 at default).
- Throughput: one transaction per 3 cycles (write) or RD_LATENCY+3 cycles (read).
- mem_addr/mem_wdata hold their last value in IDLE; mem_we=0 outside ISSUE.
- Req rules:
  - req is only sampled in IDLE.
  - A req still high in the cycle after ack is a new transaction.
  - Changing fields while req is high and un-acked is illegal; the latched values win.
- Simultaneous requests: m0 wins unless starve_cnt==STARVE_LIMIT.
- Unacked m1 m1_rdata is never overwritten by an m0 transaction, and vice versa.

Optional Feature:
- Macro: MEM_ARB_PROTECT_EN.
- When defined:
  - Adds output m1_err (1 bit).
  - An m1 write with m1_addr[31:16]==16'hffff (MMIO window) or m1_addr[31:16]==16'h1c09 (exception vector window) keeps mem_we=0 in ISSUE.
  - Such a write still takes the normal write timing and acks with m1_err=1 in the ack cycle; otherwise m1_err=0.
  - m1 reads and all m0 accesses are unaffected.
- When undefined: no m1_err port, and m1 writes are never filtered.

Test Plan:
- Reset, then m0 write addr=0x0000_0010 data=0xDEADBEEF -> mem_we=1 for exactly 1 cycle with mem_addr=0x10; m0_ack 2 cycles after the req is sampled.
- m0 read of 0x10 with memory model RD_LATENCY=1 -> m0_ack 3 cycles after the sampling cycle; m0_rdata=0xDEADBEEF, held after ack.
- m0_req and m1_req asserted together for one transaction each -> m0 served first, m1 second; owner goes 0 then 1.
- m0_req held continuously and m1_req held, STARVE_LIMIT=8 -> m1 granted after exactly 8 m0 grants; starve_cnt then 0 and the m0 streak resumes.
- Assert reset=0 during a read's WAIT state -> no ack; all outputs 0 asynchronously; next transaction after release completes normally.
- MEM_ARB_PROTECT_EN defined, m1 write to 0xFFFF_0000 -> mem_we stays 0; m1_ack with m1_err=1; m1 write to 0x0000_0020 -> mem_we=1, m1_err=0.
